fwd_hazard_unit: RTL

Generates the 2-bit operand-select codes for the EX-stage ALU operand forwarding muxes, plus the load-use stall request, in the 5-stage KLP32 pipeline. Keeps its own shadow scoreboard of destination registers for the EX, MEM and WB stages, fed from the ID stage. Selects are driven from registered state only, so they are stable from the start of each cycle.

---
 rtl/fwd_hazard_unit_pkg.sv | 35 +++
 rtl/fwd_hazard_unit_fwd_sel_gen.sv | 27 ++
 rtl/fwd_hazard_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared KLP32 pipeline types for the forwarding/hazard unit: operand-select
// encoding, scoreboard slot layout and the slot match helpers.
package fwd_hazard_unit_pkg;

   localparam int unsigned KLP_REG_W = 5;

   // Encoding matches the existing 3:1 EX operand mux
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic                 valid;
      logic [KLP_REG_W-1:0] rd;
      logic                 reg_write;
      logic                 mem_read;
   } sb_slot_t;

   localparam sb_slot_t SB_BUBBLE = '0;

   // A slot can feed a forwarding mux only if it really writes a non-x0 register
   function automatic logic is_fwd_src(input sb_slot_t s);
      return s.valid && s.reg_write && (s.rd != '0);
   endfunction

   // A load in this slot produces a register the ID instruction wants to read
   function automatic logic load_hit(input sb_slot_t s,
                                     input logic [KLP_REG_W-1:0] rs1,
                                     input logic [KLP_REG_W-1:0] rs2);
      return s.valid && s.mem_read && (s.rd != '0) && ((s.rd == rs1) || (s.rd == rs2));
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_sel_gen.sv
// Operand-select generator for one EX source index against the MEM and WB
// scoreboard slots. Instantiated once per ALU operand.
module fwd_sel_gen
   import fwd_hazard_unit_pkg::*;
(
   input  logic                 en_i,
   input  logic [KLP_REG_W-1:0] src_i,
   input  sb_slot_t             mem_slot_i,
   input  sb_slot_t             wb_slot_i,
   output fwd_sel_e             sel_o
);

   // The load flag plays no part in operand selection
   logic unused_mem_read;
   assign unused_mem_read = mem_slot_i.mem_read ^ wb_slot_i.mem_read;

   // MEM holds the younger producer, so it wins over WB
   always_comb begin
      sel_o = FWD_RF;
      if (en_i && is_fwd_src(mem_slot_i) && (mem_slot_i.rd == src_i)) begin
         sel_o = FWD_MEM;
      end else if (en_i && is_fwd_src(wb_slot_i) && (wb_slot_i.rd == src_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding selects and load-use stall for the KLP32
// 5-stage pipeline. A shadow scoreboard of the EX/MEM/WB destinations is fed
// from ID; the selects depend only on that registered state.
// Optional: define FWD_PERF_CNT_EN to add the saturating stall_cycles counter.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int unsigned REG_W = KLP_REG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             flush,
   input  logic             hold,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   sb_slot_t         ex_q, ex_d;
   sb_slot_t         mem_q, mem_d;
   sb_slot_t         wb_q, wb_d;
   logic [REG_W-1:0] ex_rs1_q, ex_rs1_d;
   logic [REG_W-1:0] ex_rs2_q, ex_rs2_d;
   logic             ex_load_hit;
   logic             mem_load_hit;
   fwd_sel_e         sel_a;
   fwd_sel_e         sel_b;

   // Loads cannot forward out of MEM, so a consumer waits while the load sits in EX or MEM
   assign ex_load_hit  = load_hit(ex_q, id_rs1, id_rs2);
   assign mem_load_hit = load_hit(mem_q, id_rs1, id_rs2);
   assign stall        = id_valid && !flush && !hold && (ex_load_hit || mem_load_hit);

   // Scoreboard advance: shift on a free-running cycle, freeze on hold, squash on flush
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      ex_d     = ex_q;
      ex_rs1_d = ex_rs1_q;
      ex_rs2_d = ex_rs2_q;
      mem_d    = mem_q;
      wb_d     = wb_q;
      if (!hold) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         if (id_valid && !stall && !flush) begin
            ex_d     = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
            ex_rs1_d = id_rs1;
            ex_rs2_d = id_rs2;
         end else begin
            ex_d     = SB_BUBBLE;
            ex_rs1_d = '0;
            ex_rs2_d = '0;
         end
      end else if (flush) begin
         ex_d     = SB_BUBBLE;
         ex_rs1_d = '0;
         ex_rs2_d = '0;
      end
   end

   // Slot registers; reset wins over hold and flush
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples its pre-edge inputs.
      if (rst) begin
         ex_q     <= SB_BUBBLE;
         mem_q    <= SB_BUBBLE;
         wb_q     <= SB_BUBBLE;
         ex_rs1_q <= '0;
         ex_rs2_q <= '0;
      end else begin
         ex_q     <= ex_d;
         mem_q    <= mem_d;
         wb_q     <= wb_d;
         ex_rs1_q <= ex_rs1_d;
         ex_rs2_q <= ex_rs2_d;
      end
   end

   fwd_sel_gen u_sel_a (
      .en_i       (ex_q.valid),
      .src_i      (ex_rs1_q),
      .mem_slot_i (mem_q),
      .wb_slot_i  (wb_q),
      .sel_o      (sel_a)
   );

   fwd_sel_gen u_sel_b (
      .en_i       (ex_q.valid),
      .src_i      (ex_rs2_q),
      .mem_slot_i (mem_q),
      .wb_slot_i  (wb_q),
      .sel_o      (sel_b)
   );

   assign fwd_a_sel = sel_a;
   assign fwd_b_sel = sel_b;

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   // Saturating count of stalled, non-held cycles
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && !hold && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   // Counter register, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule
